// File: rtl/lda_cmd_regs.sv
// Avalon-MM command registers for the line-draw engine: shadow START/END/COLOR, GO launches a line.
// Optional `LDA_CMD_FIFO_EN queues GO commands in a FIFO_DEPTH-entry buffer.
module lda_cmd_regs #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  s_address,
   input  logic        s_read,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic        s_waitrequest,
   output logic [8:0]  o_x0,
   output logic [8:0]  o_x1,
   output logic [7:0]  o_y0,
   output logic [7:0]  o_y1,
   output logic [2:0]  o_color,
   output logic        o_start,
   input  logic        i_line_done,
   output logic        o_busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_DRAW   = 2'd2;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end

   logic [1:0]  state_q, state_d;
   logic        mode_q;
   logic        ovf_q, ovf_d;
   logic [16:0] start_q, end_q;
   logic [2:0]  color_q;
   logic        wr_acc, go_wr, load, drop;
   logic [36:0] load_cmd;

   assign wr_acc = s_write & ~s_waitrequest;
   assign go_wr  = wr_acc & (s_address == 3'd2);

`ifdef LDA_CMD_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [36:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wptr_q, rptr_q;
   logic        empty, full, push, pop;
   logic        unused_rd;

   assign unused_rd     = s_read;
   assign empty         = (wptr_q == rptr_q);
   assign full          = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push          = go_wr & ~full;
   assign pop           = (state_q == ST_IDLE) & ~empty;
   assign load          = pop;
   assign load_cmd      = mem_q[rptr_q[AW-1:0]];
   assign o_busy        = (state_q != ST_IDLE) | ~empty;
   assign s_waitrequest = ~mode_q & s_write & (s_address == 3'd2) & full;
   // Only poll mode can present an accepted GO while full.
   assign drop          = go_wr & full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + (AW + 1)'(1);
         if (pop)  rptr_q <= rptr_q + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= {start_q, end_q, color_q};
   end
`else
   assign load          = go_wr & (state_q == ST_IDLE);
   assign load_cmd      = {start_q, end_q, color_q};
   assign o_busy        = (state_q != ST_IDLE);
   assign s_waitrequest = ~mode_q & o_busy & (s_read | s_write);
   assign drop          = go_wr & o_busy;
`endif

   logic unused_wdata;
   assign unused_wdata = ^s_writedata[31:17];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (load) state_d = ST_LAUNCH;
         ST_LAUNCH: state_d = ST_DRAW;
         ST_DRAW:   if (i_line_done) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop) ovf_d = 1'b1;
      else if (wr_acc && s_address == 3'd1) ovf_d = 1'b0;
   end

   assign o_start = (state_q == ST_LAUNCH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ovf_q   <= 1'b0;
         mode_q  <= 1'b0;
         start_q <= '0;
         end_q   <= '0;
         color_q <= '0;
         o_x0    <= '0;
         o_y0    <= '0;
         o_x1    <= '0;
         o_y1    <= '0;
         o_color <= '0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         if (wr_acc) begin
            case (s_address)
               3'd0:    mode_q  <= s_writedata[0];
               3'd3:    start_q <= s_writedata[16:0];
               3'd4:    end_q   <= s_writedata[16:0];
               3'd5:    color_q <= s_writedata[2:0];
               default: ;
            endcase
         end
         // Command layout is {start[16:0], end[16:0], color[2:0]}.
         if (load) begin
            o_x0    <= load_cmd[28:20];
            o_y0    <= load_cmd[36:29];
            o_x1    <= load_cmd[11:3];
            o_y1    <= load_cmd[19:12];
            o_color <= load_cmd[2:0];
         end
      end
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         3'd0:    s_readdata = {31'b0, mode_q};
         3'd1:    s_readdata = {29'b0, ovf_q, 1'b0, o_busy};
         3'd3:    s_readdata = {15'b0, start_q};
         3'd4:    s_readdata = {15'b0, end_q};
         3'd5:    s_readdata = {29'b0, color_q};
         default: s_readdata = '0;
      endcase
   end

endmodule

// File: doc/lda_cmd_regs.md
LDA_CMD_REGS -- requirements
Module: lda_cmd_regs

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth, power of two, used only when LDA_CMD_FIFO_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; every register samples on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port s_address  input  3  Avalon-MM word address.
REQ-005 SHALL have ports s_read / s_write  input  1 each  Avalon-MM read and write strobes.
REQ-006 SHALL have port s_writedata  input  32  write data.
REQ-007 SHALL have port s_readdata  output  32  read data, combinational, valid while s_read=1 and s_waitrequest=0.
REQ-008 SHALL have port s_waitrequest  output  1  stall to the host.
REQ-009 SHALL have ports o_x0/o_x1  output  9 each and o_y0/o_y1  output  8 each  endpoints to the line datapath.
REQ-010 SHALL have port o_color  output  3  line color.
REQ-011 SHALL have port o_start  output  1  one-cycle pulse launching a line.
REQ-012 SHALL have port i_line_done  input  1  line complete, from the controller.
REQ-013 SHALL have port o_busy  output  1  line in flight or queued.

Function
REQ-014 SHALL decode the register map: 0 MODE (bit0: 0=stall, 1=poll), 1 STATUS (read-only), 2 GO, 3 START, 4 END, 5 COLOR; other addresses read 0 and ignore writes.
REQ-015 SHALL pack START/END as x=[8:0], y=[16:9] and COLOR as [2:0]; excess bits are ignored.
REQ-016 SHALL hold START/END/COLOR in shadow registers readable at their addresses; shadow writes never disturb the o_* outputs.
REQ-017 SHALL use states IDLE, LAUNCH, DRAW: a GO write accepted in IDLE copies the shadows to o_*, then the FSM enters LAUNCH.
REQ-018 SHALL assert o_start for exactly the LAUNCH cycle (the cycle after the GO write), then enter DRAW.
REQ-019 SHALL return from DRAW to IDLE on the cycle i_line_done=1; i_line_done outside DRAW is ignored.
REQ-020 SHALL drive o_busy=1 in LAUNCH and DRAW; STATUS reads {29'b0, overflow, 1'b0, o_busy}.
REQ-021 SHALL hold o_* stable from LAUNCH until the FSM returns to IDLE.
REQ-022 In stall mode, SHALL assert s_waitrequest on any access while o_busy=1 (non-FIFO build), releasing it combinationally once the FSM is IDLE.
REQ-023 In poll mode, SHALL never assert s_waitrequest; a GO write while busy is dropped and sets sticky overflow (STATUS bit2), cleared by a write to STATUS.
REQ-024 A GO write coincident with i_line_done in DRAW SHALL be treated as busy: stalled in stall mode, dropped in poll mode.

Reset
REQ-025 SHALL, while reset=0, clear asynchronously: FSM=IDLE, MODE=0, shadows=0, o_*=0, o_start=0, o_busy=0, overflow=0, s_waitrequest=0, FIFO empty.
REQ-026 Reset asserted mid-line SHALL abandon the line; no o_start follows deassertion.

Configuration
REQ-027 Macro LDA_CMD_FIFO_EN defined: GO pushes {START,END,COLOR} into a FIFO_DEPTH queue; IDLE pops the head into o_* when non-empty; o_busy = not IDLE or FIFO non-empty.
REQ-028 With LDA_CMD_FIFO_EN, stall mode SHALL stall only GO writes while full; poll mode SHALL drop GO writes while full and set overflow; push and pop in the same cycle are both honoured.
REQ-029 Macro undefined: no queue, behaviour per REQ-017..024.

Verification
REQ-030 Reset, write START=0x00A05 (x=5,y=5), END=0x14032 (x=50,y=160), COLOR=3, GO -> o_start high exactly one cycle after the GO write with o_x0=5,o_y0=5,o_x1=50,o_y1=160,o_color=3.
REQ-031 Stall mode, read STATUS during DRAW -> s_waitrequest=1 until the cycle i_line_done=1, then the read returns 0.
REQ-032 Poll mode, GO during DRAW -> no o_start, STATUS=0x5; write STATUS -> STATUS=0x1.
REQ-033 GO coincident with i_line_done -> stalled (stall mode) or dropped with overflow set (poll mode).
REQ-034 Reset pulled low in DRAW -> all outputs 0 immediately, no o_start afterwards.
REQ-035 FIFO build, depth 4, poll mode, 6 GOs back-to-back -> 5 lines launched in order, overflow=1, o_busy falls after the 5th i_line_done.
